sd_cmd_phy: RTL

//  Bit-level CMD-line engine between the SD host command controller and the CMD pad.
//  - Accepts a command index and argument, then builds the 48-bit frame with CRC7.
//  - Shifts the frame out one bit per sd_tick.
//  - Optionally captures the 48-bit response and reports done, timeout, CRC and index status.
//  - Upstream: command controller (new_command/index/argument). Downstream: tri-state CMD pad.

---
 rtl/sd_cmd_phy.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/sd_cmd_phy.sv
// sd_cmd_phy -- bit-level SD CMD-line engine.
//
// Builds the 48-bit command frame (start, transmission, index, argument,
// CRC7, end bit) and shifts it out MSB first, one bit per sd_tick. It can
// then wait for a 48-bit response, capture it and report the status fields.
//
// Optional feature macro: SD_CMD_RESP_CRC_CHECK_EN
//   defined   -> response CRC7 is recomputed and compared (resp_crc_err)
//   undefined -> no receive CRC logic, resp_crc_err stays 0 (R3 responses)
//
// Ports
//   clk_host, reset_host       : clock, async active-low reset
//   sd_tick                    : one-cycle bit-time strobe
//   cmd_start, cmd_index,
//   cmd_argument, resp_expected,
//   index_check                : request, sampled when accepted (busy=0)
//   CMD_PIN_IN/OUT, io_enable_cmd : pad interface (io_enable_cmd=1 drives)
//   busy, cmd_done             : transaction status / completion pulse
//   resp_index, resp_arg       : captured response fields
//   resp_timeout, resp_crc_err,
//   resp_index_err             : response status flags
module sd_cmd_phy #(
  parameter int TIMEOUT_TICKS = 64
) (
  input  logic        clk_host,
  input  logic        reset_host,
  input  logic        sd_tick,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_argument,
  input  logic        resp_expected,
  input  logic        index_check,
  input  logic        CMD_PIN_IN,
  output logic        CMD_PIN_OUT,
  output logic        io_enable_cmd,
  output logic        busy,
  output logic        cmd_done,
  output logic [5:0]  resp_index,
  output logic [31:0] resp_arg,
  output logic        resp_timeout,
  output logic        resp_crc_err,
  output logic        resp_index_err
);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_CHECK, S_DONE} state_t;

  // CRC7, x^7+x^3+1, zero seed, MSB first
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  state_t        state, state_d;
  logic [47:0]   tx_sh, rx_sh, tx_frame;
  logic [5:0]    bit_cnt;
  logic [TW-1:0] to_cnt;
  logic [5:0]    idx_q;
  logic          resp_q, ichk_q;
  logic          accept;

  assign tx_frame = {2'b01, cmd_index, cmd_argument,
                     crc7({2'b01, cmd_index, cmd_argument}), 1'b1};

  // DONE already reports not-busy so a new command can be taken there
  assign busy     = (state != S_IDLE) && (state != S_DONE);
  assign cmd_done = (state == S_DONE);
  assign accept   = cmd_start && !busy;

  always_ff @(posedge clk_host or negedge reset_host) begin
    if (!reset_host) state <= S_IDLE;
    else             state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE, S_DONE: state_d = accept ? S_SEND : S_IDLE;
      S_SEND:  if (sd_tick && bit_cnt == 6'd48) state_d = resp_q ? S_WAIT : S_DONE;
      S_WAIT:  if (sd_tick) begin
                 if (!CMD_PIN_IN)                               state_d = S_RECV;
                 else if (to_cnt == TW'(TIMEOUT_TICKS - 1))     state_d = S_DONE;
               end
      S_RECV:  if (sd_tick && bit_cnt == 6'd47) state_d = S_CHECK;
      S_CHECK: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_host or negedge reset_host) begin
    if (!reset_host) begin
      CMD_PIN_OUT    <= 1'b1;
      io_enable_cmd  <= 1'b0;
      tx_sh          <= '0;
      rx_sh          <= '0;
      bit_cnt        <= '0;
      to_cnt         <= '0;
      idx_q          <= '0;
      resp_q         <= 1'b0;
      ichk_q         <= 1'b0;
      resp_index     <= '0;
      resp_arg       <= '0;
      resp_timeout   <= 1'b0;
      resp_crc_err   <= 1'b0;
      resp_index_err <= 1'b0;
    end else if (accept) begin
      // a tick coincident with accept is deliberately not used
      tx_sh          <= tx_frame;
      idx_q          <= cmd_index;
      resp_q         <= resp_expected;
      ichk_q         <= index_check;
      bit_cnt        <= '0;
      to_cnt         <= '0;
      resp_timeout   <= 1'b0;
      resp_crc_err   <= 1'b0;
      resp_index_err <= 1'b0;
    end else begin
      case (state)
        S_SEND: if (sd_tick) begin
          if (bit_cnt != 6'd48) begin
            CMD_PIN_OUT   <= tx_sh[47];
            io_enable_cmd <= 1'b1;
            tx_sh         <= {tx_sh[46:0], 1'b1};
            bit_cnt       <= bit_cnt + 6'd1;
          end else begin
            // tick after the end bit hands the line back to the card
            CMD_PIN_OUT   <= 1'b1;
            io_enable_cmd <= 1'b0;
            bit_cnt       <= '0;
          end
        end
        S_WAIT: if (sd_tick) begin
          if (!CMD_PIN_IN) begin
            rx_sh   <= {rx_sh[46:0], 1'b0};
            bit_cnt <= 6'd1;
          end else begin
            to_cnt <= to_cnt + TW'(1);
            if (to_cnt == TW'(TIMEOUT_TICKS - 1)) resp_timeout <= 1'b1;
          end
        end
        S_RECV: if (sd_tick) begin
          rx_sh   <= {rx_sh[46:0], CMD_PIN_IN};
          bit_cnt <= bit_cnt + 6'd1;
        end
        S_CHECK: begin
          resp_index     <= rx_sh[45:40];
          resp_arg       <= rx_sh[39:8];
          resp_index_err <= rx_sh[46] | ~rx_sh[0] | (ichk_q & (rx_sh[45:40] != idx_q));
`ifdef SD_CMD_RESP_CRC_CHECK_EN
          resp_crc_err   <= (crc7(rx_sh[47:8]) != rx_sh[7:1]);
`endif
        end
        default: ;
      endcase
    end
  end

`ifndef SD_CMD_RESP_CRC_CHECK_EN
  // received CRC field is ignored in this build
  logic unused_rx_crc;
  assign unused_rx_crc = ^rx_sh[7:1];
`endif

endmodule
